// File: rtl/data_sram_like_slave.sv
// Responder for the data-side SRAM-like bus: word-addressed RAM plus an in-order
// pending-response queue that answers each accepted request after LATENCY cycles.
module data_sram_like_slave #(
  parameter int MEM_AW    = 10,
  parameter int LATENCY   = 2,
  parameter int QUEUE_DEP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW = (QUEUE_DEP > 1) ? $clog2(QUEUE_DEP) : 1;
  localparam int CW = $clog2(QUEUE_DEP + 1);
  localparam int TW = 4;

  typedef struct packed {
    logic          is_write;
    logic [31:0]   data;
    logic [TW-1:0] timer;
  } entry_t;

  logic [31:0]   mem_q [2**MEM_AW];
  entry_t        q_q     [QUEUE_DEP];
  entry_t        q_d     [QUEUE_DEP];
  logic          valid_q [QUEUE_DEP];
  logic          valid_d [QUEUE_DEP];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic              accept;
  logic              pop;
  logic [MEM_AW-1:0] idx;
  logic [31:0]       rd_word;
  logic              unused_bits;

  // Size is informational and the address is word-granular with high bits aliased.
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:MEM_AW+2], data_sram_addr[1:0]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEP - 1)) ? '0 : p + PW'(1);
  endfunction

  assign idx               = data_sram_addr[MEM_AW+1:2];
  assign rd_word           = mem_q[idx];
  assign data_sram_addr_ok = !reset && (count_q < CW'(QUEUE_DEP));
  assign accept            = data_sram_req && data_sram_addr_ok;
  assign pop               = valid_q[head_q] && (q_q[head_q].timer == '0);
  assign data_sram_data_ok = pop;
  assign data_sram_rdata   = (pop && !q_q[head_q].is_write) ? q_q[head_q].data : 32'h0;

  // NOTE: the RAM array has no reset; only the queue bookkeeping is cleared, so
  // writes performed before a reset survive it.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) mem_q[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  // NOTE: every output of this block is given a default first so no path leaves
  // a value unassigned and infers a latch.
  always_comb begin
    q_d     = q_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    for (int i = 0; i < QUEUE_DEP; i++) begin
      if (valid_q[i] && (q_q[i].timer != '0)) q_d[i].timer = q_q[i].timer - TW'(1);
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end
    // The tail slot is always free on accept because acceptance requires count < QUEUE_DEP.
    if (accept) begin
      q_d[tail_q].is_write = data_sram_wr;
      q_d[tail_q].data     = data_sram_wr ? 32'h0 : rd_word;
      q_d[tail_q].timer    = TW'(LATENCY - 1);
      valid_d[tail_q]      = 1'b1;
      tail_d               = ptr_inc(tail_q);
    end
    count_d = count_q + CW'(accept) - CW'(pop);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed by the combinational block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEP; i++) begin
        q_q[i]     <= '0;
        valid_q[i] <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_data_sram_like_slave.sv
// Bench for data_sram_like_slave: three instances (LATENCY 2, 3, 1; QUEUE_DEP 2) checked
// against a due-cycle response model every cycle, plus hand-computed literal expectations.
module tb_data_sram_like_slave;

  localparam int N        = 3;
  localparam int DEP      = 2;
  localparam int LAT [N]  = '{2, 3, 1};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req   [N];
  logic        wr    [N];
  logic [1:0]  size  [N];
  logic [3:0]  wstrb [N];
  logic [31:0] addr  [N];
  logic [31:0] wdata [N];
  logic        aok   [N];
  logic        dok   [N];
  logic [31:0] rdata [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : gen_dut
    data_sram_like_slave #(.MEM_AW(10), .LATENCY(LAT[g]), .QUEUE_DEP(DEP)) u_dut (
      .clk               (clk),
      .reset             (reset),
      .data_sram_req     (req[g]),
      .data_sram_wr      (wr[g]),
      .data_sram_size    (size[g]),
      .data_sram_wstrb   (wstrb[g]),
      .data_sram_addr    (addr[g]),
      .data_sram_wdata   (wdata[g]),
      .data_sram_addr_ok (aok[g]),
      .data_sram_data_ok (dok[g]),
      .data_sram_rdata   (rdata[g])
    );
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic        is_wr;
    logic [31:0] data;
  } resp_t;

  resp_t       pend [N][$];
  logic [31:0] mdl_mem [N][1024];
  int          cyc = 0;
  bit          chk_en = 0;

  always @(posedge reset) begin
    for (int k = 0; k < N; k++) pend[k].delete();
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        automatic int    n  = pend[k].size();
        automatic bit    ok = (n < DEP);
        automatic int    ix = int'(addr[k][11:2]);
        automatic resp_t r;
        if (n > 0 && pend[k][0].due == cyc) void'(pend[k].pop_front());
        if (req[k] && ok) begin
          r.due   = cyc + LAT[k];
          r.is_wr = wr[k];
          r.data  = wr[k] ? 32'h0 : mdl_mem[k][ix];
          if (wr[k]) begin
            for (int b = 0; b < 4; b++)
              if (wstrb[k][b]) mdl_mem[k][ix][8*b +: 8] = wdata[k][8*b +: 8];
          end
          pend[k].push_back(r);
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        automatic bit          e_aok = !reset && (pend[k].size() < DEP);
        automatic bit          e_dok = !reset && (pend[k].size() > 0) && (pend[k][0].due == cyc);
        automatic logic [31:0] e_rd  = (e_dok && !pend[k][0].is_wr) ? pend[k][0].data : 32'h0;
        check($sformatf("mdl_addr_ok[%0d]", k), 32'(aok[k]), 32'(e_aok));
        check($sformatf("mdl_data_ok[%0d]", k), 32'(dok[k]), 32'(e_dok));
        check($sformatf("mdl_rdata[%0d]", k), rdata[k], e_rd);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    req[k] = 1'b0; wr[k] = 1'b0; wstrb[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
  endtask

  task automatic drive(input int k, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    req[k] = 1'b1; wr[k] = w; size[k] = 2'd2; addr[k] = a; wdata[k] = d; wstrb[k] = s;
  endtask

  localparam bit E4_AOK [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
  localparam bit E4_DOK [8] = '{0, 0, 0, 1, 1, 0, 0, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      idle(k);
      size[k] = 2'd2;
    end

    // 1: reset held three cycles, addr_ok rises the first cycle after release
    repeat (3) begin
      @(negedge clk);
      chk_en = 1;
      for (int k = 0; k < N; k++) begin
        check("t1_aok_in_reset", 32'(aok[k]), 32'h0);
        check("t1_dok_in_reset", 32'(dok[k]), 32'h0);
        check("t1_rdata_in_reset", rdata[k], 32'h0);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) check("t1_aok_after_reset", 32'(aok[k]), 32'h1);

    // 2: write then read-after-write on the LATENCY=2 instance
    drive(0, 1'b1, 32'h40, 32'h11223344, 4'hF);
    drive(1, 1'b1, 32'h80, 32'hCAFEF00D, 4'hF);
    step;
    drive(0, 1'b0, 32'h40, 32'h0, 4'h0);
    idle(1);
    step;
    idle(0);
    @(negedge clk);
    check("t2_write_dok", 32'(dok[0]), 32'h1);
    check("t2_write_rdata", rdata[0], 32'h0);
    step;
    @(negedge clk);
    check("t2_read_dok", 32'(dok[0]), 32'h1);
    check("t2_read_rdata", rdata[0], 32'h11223344);

    // 3: byte-lane write merges into the stored word
    step;
    drive(0, 1'b1, 32'h42, 32'h00AB0000, 4'b0100);
    step;
    drive(0, 1'b0, 32'h40, 32'h0, 4'h0);
    step;
    idle(0);
    @(negedge clk);
    check("t3_write_dok", 32'(dok[0]), 32'h1);
    step;
    @(negedge clk);
    check("t3_read_dok", 32'(dok[0]), 32'h1);
    check("t3_read_rdata", rdata[0], 32'h11AB3344);

    // 4: LATENCY=3 with two queue slots stalls the third read until the first retires
    step;
    drive(1, 1'b0, 32'h80, 32'h0, 4'h0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check($sformatf("t4_aok_c%0d", j), 32'(aok[1]), 32'(E4_AOK[j]));
      check($sformatf("t4_dok_c%0d", j), 32'(dok[1]), 32'(E4_DOK[j]));
      if (E4_DOK[j]) check($sformatf("t4_rdata_c%0d", j), rdata[1], 32'hCAFEF00D);
      step;
      if (j == 4) idle(1);
    end

    // 5: async reset mid-cycle drops pending reads; RAM contents survive
    drive(1, 1'b0, 32'h80, 32'h0, 4'h0);
    step;
    step;
    idle(1);
    #2 reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t5_no_dok_after_reset", 32'(dok[1]), 32'h0);
      check("t5_aok_low_in_reset", 32'(aok[1]), 32'h0);
    end
    step;
    reset = 1'b0;
    drive(1, 1'b0, 32'h80, 32'h0, 4'h0);
    step;
    idle(1);
    @(negedge clk);
    check("t5_dok_c1", 32'(dok[1]), 32'h0);
    step;
    @(negedge clk);
    check("t5_dok_c2", 32'(dok[1]), 32'h0);
    step;
    @(negedge clk);
    check("t5_dok_c3", 32'(dok[1]), 32'h1);
    check("t5_rdata_survives", rdata[1], 32'hCAFEF00D);

    // 6: LATENCY=1 back-to-back write/read pairs with aliased address bits
    step;
    for (int c = 0; c < 32; c++) begin
      automatic int i = c / 2;
      if (c % 2 == 0)
        drive(2, 1'b1, 32'h12345100 + 32'(i * 4), 32'hA5000000 | 32'(i << 8) | 32'(i), 4'hF);
      else
        drive(2, 1'b0, 32'h00000101 + 32'(i * 4), 32'h0, 4'h0);
      @(negedge clk);
      check($sformatf("t6_aok_c%0d", c), 32'(aok[2]), 32'h1);
      if (c > 0) check($sformatf("t6_dok_c%0d", c), 32'(dok[2]), 32'h1);
      step;
    end
    idle(2);
    @(negedge clk);
    check("t6_last_dok", 32'(dok[2]), 32'h1);
    check("t6_last_rdata", rdata[2], 32'hA5000F0F);
    step;
    @(negedge clk);
    check("t6_idle_dok", 32'(dok[2]), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
